// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants for the keypad-set board clock
package clock_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns; element k is digit k.
    localparam logic [9:0][7:0] SEG_CODES = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [2:0] LAST_POS = 3'd5;
    localparam logic [3:0] H_ONE_MAX_20S = 4'd3;

    // Largest digit accepted at each cursor position (position 0 = hour tens).
    localparam logic [5:0][3:0] POS_MAX = {4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd2};

    function automatic logic [7:0] com_pattern(input logic [2:0] idx);
        return ~(8'h80 >> idx);
    endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// rtl/seven_seg_dec.sv - BCD to active-low seven-segment pattern, blank above 9
module seven_seg_dec
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) seg = SEG_CODES[bcd];
    end

endmodule

// File: rtl/keypad_set_clock.sv
// rtl/keypad_set_clock.sv - HH:MM:SS clock with keypad time entry and 12/24-hour display
module keypad_set_clock
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 1000,
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_mode,
    input  logic       hour12,
    input  logic [9:0] keypad,
    output logic [7:0] seg_data,
    output logic [7:0] seg_com,
    output logic       pm,
    output logic [2:0] entry_pos
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    // Digit arrays: element 0 = hour tens ... element 5 = second ones.
    logic [5:0][3:0] tm, sh, sh_next, src;
    logic [PW-1:0]   presc;
    logic [2:0]      cursor, scan_idx;
    logic [SW-1:0]   scan_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            blink_on, set_q;
    logic [9:0]      key_q, key_prev, key_low;
    logic            key_onehot, key_event, set_rise, accept, pm_next;
    logic [3:0]      key_digit, max_digit, h_ten, h_one, digit;
    logic [4:0]      hour24, hour_disp;
    logic [7:0]      seg_dec;

    function automatic logic [5:0][3:0] next_time(input logic [5:0][3:0] t);
        logic [5:0][3:0] n;
        n = t;
        if (t[5] != 4'd9) n[5] = t[5] + 4'd1;
        else begin
            n[5] = 4'd0;
            if (t[4] != 4'd5) n[4] = t[4] + 4'd1;
            else begin
                n[4] = 4'd0;
                if (t[3] != 4'd9) n[3] = t[3] + 4'd1;
                else begin
                    n[3] = 4'd0;
                    if (t[2] != 4'd5) n[2] = t[2] + 4'd1;
                    else begin
                        n[2] = 4'd0;
                        if (t[0] == 4'd2 && t[1] == 4'd3) begin
                            n[0] = 4'd0;
                            n[1] = 4'd0;
                        end else if (t[1] == 4'd9) begin
                            n[0] = t[0] + 4'd1;
                            n[1] = 4'd0;
                        end else n[1] = t[1] + 4'd1;
                    end
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        key_low    = ~key_q;
        key_onehot = (key_low != '0) && ((key_low & (key_low - 10'd1)) == '0);
        key_event  = key_onehot && (key_prev == '1);
        key_digit  = '0;
        for (int i = 0; i < 10; i++)
            if (key_low[i]) key_digit = 4'(i);
    end

    assign set_rise  = set_mode & ~set_q;
    assign max_digit = (cursor == 3'd1) ? ((sh[0] < 4'd2) ? 4'd9 : H_ONE_MAX_20S)
                                        : POS_MAX[cursor];
    assign accept    = set_mode && !set_rise && key_event && (key_digit <= max_digit);

    // Writing a 2 into hour tens pulls an out-of-range hour ones back to 3.
    always_comb begin
        sh_next         = sh;
        sh_next[cursor] = key_digit;
        if (cursor == 3'd0 && key_digit == 4'd2 && sh[1] > H_ONE_MAX_20S)
            sh_next[1] = H_ONE_MAX_20S;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tm       <= '0;
            sh       <= '0;
            presc    <= '0;
            cursor   <= '0;
            set_q    <= 1'b0;
            key_q    <= '1;
            key_prev <= '1;
        end else begin
            key_q    <= keypad;
            key_prev <= key_q;
            set_q    <= set_mode;
            if (!set_mode) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    tm    <= next_time(tm);
                end else presc <= presc + 1'b1;
            end
            if (set_rise) begin
                sh     <= tm;
                cursor <= '0;
            end else if (accept) begin
                sh <= sh_next;
                if (cursor == LAST_POS) begin
                    tm     <= sh_next;
                    presc  <= '0;
                    cursor <= '0;
                end else cursor <= cursor + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!set_mode || set_rise || accept) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else blink_cnt <= blink_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == LAST_POS) ? 3'd0 : scan_idx + 3'd1;
        end else scan_cnt <= scan_cnt + 1'b1;
    end

    always_comb begin
        src       = set_mode ? sh : tm;
        hour24    = 5'(src[0]) * 5'd10 + 5'(src[1]);
        hour_disp = hour24;
        if (hour12) begin
            if (hour24 == 5'd0) hour_disp = 5'd12;
            else if (hour24 > 5'd12) hour_disp = hour24 - 5'd12;
        end
        if (hour_disp >= 5'd20) begin
            h_ten = 4'd2;
            h_one = 4'(hour_disp - 5'd20);
        end else if (hour_disp >= 5'd10) begin
            h_ten = 4'd1;
            h_one = 4'(hour_disp - 5'd10);
        end else begin
            h_ten = 4'd0;
            h_one = 4'(hour_disp);
        end
        if (hour12 && h_ten == 4'd0) h_ten = 4'hF;
        case (scan_idx)
            3'd0:    digit = h_ten;
            3'd1:    digit = h_one;
            default: digit = src[scan_idx];
        endcase
        if (set_mode && scan_idx == cursor && !blink_on) digit = 4'hF;
        pm_next = hour12 && (hour24 >= 5'd12);
    end

    seven_seg_dec u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_com  <= 8'hFF;
            seg_data <= SEG_BLANK;
            pm       <= 1'b0;
        end else begin
            seg_com  <= com_pattern(scan_idx);
            seg_data <= seg_dec;
            pm       <= pm_next;
        end
    end

    assign entry_pos = cursor;

endmodule
